branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Sequences branch resolution for the 5-stage CPU pipeline.
- Captures a conditional branch in ID and waits for the ALU flags from EX.
- Decides taken/not-taken, then drives the PC redirect mux plus IF/ID flush and ID stall for the required number of cycles.
- Keeps saturating performance counters of resolved and taken branches. Predict-not-taken: sequential fetch continues until a redirect.

Parameters:
- ADDR_W, 16, PC/target address width
- FLUSH_CYCLES, 1, extra cycles flush_if/flush_id stay high after the redirect cycle (0 to 3)
- CNT_W, 16, perf counter width

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID stage holds a valid instruction
- id_opcode  input  5  opcode in ID
- id_target  input  ADDR_W  computed branch target in ID
- stall_in  input  1  global pipeline hold (memory stall)
- ex_flags_valid  input  1  ex_flags are valid for the branch now in EX
- ex_flags  input  2  ALU flags: [1] = equal/zero, [0] = less-than
- cnt_clear  input  1  synchronous clear of both counters
- pc_sel  output  1  1 = load pc_redirect into the PC
- pc_redirect  output  ADDR_W  redirect target
- flush_if  output  1  squash the IF/ID register
- flush_id  output  1  squash the ID/EX register
- stall_id  output  1  hold ID (a second branch is waiting)
- busy  output  1  FSM not IDLE
- br_resolved_cnt  output  CNT_W  resolved branches, saturating
- br_taken_cnt  output  CNT_W  taken branches, saturating

Behaviour:
- Reset: state IDLE. Every output is 0; captured target and opcode are 0. Async reset asserted mid-operation aborts any pending redirect, with no pc_sel pulse.
- Branch opcodes (package constants): BEQ = 5'b10011, BLT = 5'b10100, BGT = 5'b10101, BNE = 5'b10110. Any other opcode is not a branch.
- Taken rules:
  - BEQ: ex_flags[1] = 1
  - BNE: ex_flags[1] = 0
  - BLT: ex_flags[0] = 1
  - BGT: ex_flags[0] = 0
- IDLE:
  - On id_valid & is_branch(id_opcode) & !stall_in: latch id_opcode and id_target, then go to RESOLVE.
  - If stall_in is high, stay in IDLE and capture nothing.
- RESOLVE:
  - When stall_in is high, hold state and ignore ex_flags_valid.
  - On ex_flags_valid & !stall_in: increment resolved_cnt. If taken, increment taken_cnt and go to REDIRECT; otherwise go to IDLE.
  - A branch may be captured again on the cycle after the return to IDLE.
  - stall_id = id_valid & is_branch(id_opcode) while in RESOLVE. Non-branch instructions in ID are not stalled.
- REDIRECT (Moore outputs):
  - pc_sel = 1, pc_redirect = latched target, flush_if = flush_id = 1.
  - If stall_in is high, hold state with the outputs unchanged, because the PC only loads when unstalled.
  - Otherwise go to FLUSH if FLUSH_CYCLES > 0, else to IDLE.
- FLUSH:
  - flush_if = flush_id = 1, pc_sel = 0. A down-counter loaded with FLUSH_CYCLES counts once per unstalled cycle; exit to IDLE when it reaches 1.
  - id_valid is ignored in REDIRECT and FLUSH because ID content is being squashed.
- Outputs are combinational from registered state only. There is no combinational path from ex_flags to pc_sel.
- Latency: flags valid in cycle M (unstalled) → pc_sel high in cycle M+1. A not-taken branch costs 0 stall cycles for non-branch followers.
- pc_redirect is 0 whenever pc_sel = 0.
- busy = (state != IDLE).
- Counters:
  - Saturate at all ones.
  - cnt_clear has priority over increments in the same cycle.
  - Taken and resolved increment in the same cycle when a branch is taken.

Decomposition:
- Package cpu_branch_pkg holds the opcode localparams, the state enum typedef (IDLE, RESOLVE, REDIRECT, FLUSH), and a branch_taken(opcode, flags) function.
- One sub-module, sat_counter (CNT_W, inc, clr), is instantiated twice.

Test Plan:
- Reset and idle check: with rst_n low, all outputs read 0. Release reset and hold id_valid = 0 for 10 cycles → busy = 0, counters = 0.
- BEQ taken: id_opcode = 10011, target = 16'h0040. Two cycles later ex_flags = 2'b10 with valid → next cycle pc_sel = 1, pc_redirect = 0040, flush_if = flush_id = 1. Flushes stay high 1 more cycle. Counters read resolved = 1, taken = 1.
- BGT not taken: ex_flags = 2'b01 → pc_sel stays 0, no flush, FSM back to IDLE. Counters read resolved = 1, taken = 0.
- Back-to-back branches: BNE in RESOLVE while BLT sits in ID → stall_id = 1 until BNE resolves, then BLT is captured the following cycle.
- Stall interaction: stall_in = 1 for 3 cycles during REDIRECT → pc_sel held for all 4 cycles, then FLUSH proceeds. stall_in during RESOLVE with valid flags → no resolution until stall_in drops.
- Corner cases:
  - Reset mid-REDIRECT → outputs 0 immediately.
  - Counter at FFFF plus a taken branch → stays FFFF.
  - cnt_clear together with an increment → counter reads 0.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared branch-unit definitions: opcodes, resolver states and the taken decision.
package cpu_branch_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned FLAG_W = 2;

    localparam logic [OPC_W-1:0] OPC_BEQ = 5'b10011;
    localparam logic [OPC_W-1:0] OPC_BLT = 5'b10100;
    localparam logic [OPC_W-1:0] OPC_BGT = 5'b10101;
    localparam logic [OPC_W-1:0] OPC_BNE = 5'b10110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } br_state_e;

    function automatic logic is_branch(input logic [OPC_W-1:0] opc);
        return (opc == OPC_BEQ) || (opc == OPC_BLT) || (opc == OPC_BGT) || (opc == OPC_BNE);
    endfunction

    // flags[1] = equal/zero, flags[0] = less-than
    function automatic logic branch_taken(input logic [OPC_W-1:0] opc,
                                          input logic [FLAG_W-1:0] flags);
        logic taken;
        taken = 1'b0;
        case (opc)
            OPC_BEQ: taken = flags[1];
            OPC_BNE: taken = !flags[1];
            OPC_BLT: taken = flags[0];
            OPC_BGT: taken = !flags[0];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencer: captures a branch in ID, resolves it on EX flags,
// then drives the PC redirect and pipeline flush/stall controls.
module branch_redirect_ctrl
    import cpu_branch_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_opcode,
    input  logic [ADDR_W-1:0] id_target,
    input  logic              stall_in,
    input  logic              ex_flags_valid,
    input  logic [1:0]        ex_flags,
    input  logic              cnt_clear,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_redirect,
    output logic              flush_if,
    output logic              flush_id,
    output logic              stall_id,
    output logic              busy,
    output logic [CNT_W-1:0]  br_resolved_cnt,
    output logic [CNT_W-1:0]  br_taken_cnt
);

    localparam int unsigned FCNT_W = 2;

    br_state_e         state_q, state_d;
    logic [OPC_W-1:0]  opc_q;
    logic [ADDR_W-1:0] tgt_q;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              capture;
    logic              inc_resolved;
    logic              inc_taken;

    // State, captured branch and flush down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opc_q   <= '0;
            tgt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (capture) begin
                opc_q <= id_opcode;
                tgt_q <= id_target;
            end
        end
    end

    // Next-state logic; every transition is gated by an unstalled pipeline
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        capture      = 1'b0;
        inc_resolved = 1'b0;
        inc_taken    = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_valid && is_branch(id_opcode) && !stall_in) begin
                    capture = 1'b1;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (ex_flags_valid && !stall_in) begin
                    inc_resolved = 1'b1;
                    if (branch_taken(opc_q, ex_flags)) begin
                        inc_taken = 1'b1;
                        state_d   = REDIRECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REDIRECT: begin
                if (!stall_in) begin
                    if (FLUSH_CYCLES > 0) begin
                        fcnt_d  = FCNT_W'(FLUSH_CYCLES);
                        state_d = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (!stall_in) begin
                    if (fcnt_q <= FCNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        fcnt_d = fcnt_q - FCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore decode from registered state; stall_id also looks at the ID contents
    assign busy        = (state_q != IDLE);
    assign pc_sel      = (state_q == REDIRECT);
    assign pc_redirect = pc_sel ? tgt_q : '0;
    assign flush_if    = (state_q == REDIRECT) || (state_q == FLUSH);
    assign flush_id    = flush_if;
    assign stall_id    = (state_q == RESOLVE) && id_valid && is_branch(id_opcode);

    sat_counter #(.CNT_W(CNT_W)) u_resolved_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_resolved),
        .clr   (cnt_clear),
        .cnt   (br_resolved_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_taken),
        .clr   (cnt_clear),
        .cnt   (br_taken_cnt)
    );

endmodule
